// File: rtl/median_pkg.sv
// Shared encodings for the median window filter family: memory handshake codes,
// controller states and border-handling modes.
package median_pkg;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam logic BORDER_CLAMP = 1'b0;
  localparam logic BORDER_ZERO  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    NEXT,
    RANK,
    DONE
  } state_t;

  // Width of a counter able to hold 0..k inclusive.
  function automatic int count_width(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/median_rank_unit.sv
// Combinational rank test of one window candidate: counts strictly-smaller and
// equal elements and flags the candidate if it sits at the median position.
module median_rank_unit
  import median_pkg::*;
#(
  parameter int K          = 9,
  parameter int DATA_WIDTH = 16,
  localparam int IW        = $clog2(K),
  localparam int CW        = count_width(K)
) (
  input  logic [K-1:0][DATA_WIDTH-1:0] i_window,
  input  logic [IW-1:0]                i_cand,
  output logic [CW-1:0]                o_lt,
  output logic [CW-1:0]                o_eq,
  output logic                         o_qualifies
);

  localparam int M = (K - 1) / 2;

  logic [DATA_WIDTH-1:0] w_cand_val;
  logic [K-1:0]          w_lt_bits;
  logic [K-1:0]          w_eq_bits;
  logic [CW:0]           w_sum;

  assign w_cand_val = i_window[i_cand];

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_cmp
      assign w_lt_bits[gi] = (i_window[gi] < w_cand_val);
      assign w_eq_bits[gi] = (i_window[gi] == w_cand_val);
    end
  endgenerate

  assign o_lt  = CW'($countones(w_lt_bits));
  assign o_eq  = CW'($countones(w_eq_bits));
  assign w_sum = {1'b0, o_lt} + {1'b0, o_eq};

  // Median position M falls inside the run [lt, lt+eq) of this value.
  assign o_qualifies = (o_lt <= CW'(M)) && (w_sum > (CW + 1)'(M));

endmodule

// File: rtl/median_window_filter.sv
// Fetches a WINDOW_SIZE^2 neighbourhood around a centre pixel from memory,
// with clamp or zero-pad border handling, and reports its median.
module median_window_filter
  import median_pkg::*;
#(
  parameter int WINDOW_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int BUS_WIDTH   = 8,
  parameter int IMG_WIDTH   = 7,
  parameter int IMG_HEIGHT  = 7,
  parameter int BASE_ADDR   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  filt_en,
  input  logic                  border_mode,
  input  logic [BUS_WIDTH-1:0]  s_row,
  input  logic [BUS_WIDTH-1:0]  s_col,
  output logic [DATA_WIDTH-1:0] filt_out,
  output logic                  filt_rdy,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] mem_odata,
  output logic [BUS_WIDTH-1:0]  mem_addr,
  output logic [1:0]            rw,
  input  logic                  mem_drdy
);

  localparam int K  = WINDOW_SIZE * WINDOW_SIZE;
  localparam int R  = (WINDOW_SIZE - 1) / 2;
  localparam int IW = $clog2(K);
  localparam int CW = count_width(K);
  localparam int JW = $clog2(WINDOW_SIZE);

  typedef logic signed [BUS_WIDTH:0] sidx_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [BUS_WIDTH-1:0]          r_row;
  logic [BUS_WIDTH-1:0]          r_col;
  logic                          r_mode;
  logic [JW-1:0]                 r_i;
  logic [JW-1:0]                 r_j;
  logic [IW-1:0]                 r_n;
  logic [IW-1:0]                 r_cand;
  logic [K-1:0][DATA_WIDTH-1:0]  r_window;
  logic [DATA_WIDTH-1:0]         r_filt_out;
  logic [BUS_WIDTH-1:0]          r_mem_addr;

  sidx_t                         w_trow;
  sidx_t                         w_tcol;
  sidx_t                         w_crow;
  sidx_t                         w_ccol;
  logic                          w_row_oob;
  logic                          w_col_oob;
  logic                          w_skip;
  logic [BUS_WIDTH-1:0]          w_addr;
  logic [CW-1:0]                 w_lt;
  logic [CW-1:0]                 w_eq;
  logic                          w_qual;
  logic                          w_rank_unused;

  // Tap coordinates are signed so taps left of / above the image go negative.
  assign w_trow = sidx_t'({1'b0, r_row}) + sidx_t'({1'b0, r_i}) - sidx_t'(R);
  assign w_tcol = sidx_t'({1'b0, r_col}) + sidx_t'({1'b0, r_j}) - sidx_t'(R);

  assign w_row_oob = (w_trow < 0) || (w_trow > sidx_t'(IMG_HEIGHT - 1));
  assign w_col_oob = (w_tcol < 0) || (w_tcol > sidx_t'(IMG_WIDTH - 1));
  assign w_skip    = (r_mode == BORDER_ZERO) && (w_row_oob || w_col_oob);

  always_comb begin
    w_crow = w_trow;
    w_ccol = w_tcol;
    if (w_trow < 0) w_crow = '0;
    else if (w_trow > sidx_t'(IMG_HEIGHT - 1)) w_crow = sidx_t'(IMG_HEIGHT - 1);
    if (w_tcol < 0) w_ccol = '0;
    else if (w_tcol > sidx_t'(IMG_WIDTH - 1)) w_ccol = sidx_t'(IMG_WIDTH - 1);
  end

  assign w_addr = BUS_WIDTH'(BASE_ADDR) + BUS_WIDTH'(w_crow) * BUS_WIDTH'(IMG_WIDTH)
                + BUS_WIDTH'(w_ccol);

  median_rank_unit #(
    .K          (K),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rank (
    .i_window    (r_window),
    .i_cand      (r_cand),
    .o_lt        (w_lt),
    .o_eq        (w_eq),
    .o_qualifies (w_qual)
  );

  // Only the qualify flag drives control; the raw counts are left for observation.
  assign w_rank_unused = ^{w_lt, w_eq};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    rw           = RW_IDLE;
    mem_addr     = r_mem_addr;
    busy         = (r_state != IDLE);
    filt_rdy     = (r_state == DONE);
    filt_out     = r_filt_out;
    case (r_state)
      IDLE: if (filt_en) w_state_next = ADDR;
      ADDR: begin
        if (w_skip) begin
          w_state_next = NEXT;
        end else begin
          rw           = RW_READ;
          mem_addr     = w_addr;
          w_state_next = WAIT;
        end
      end
      WAIT: if (mem_drdy) w_state_next = NEXT;
      NEXT: w_state_next = (r_n == IW'(K - 1)) ? RANK : ADDR;
      RANK: if (w_qual) w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_mode     <= BORDER_CLAMP;
      r_i        <= '0;
      r_j        <= '0;
      r_n        <= '0;
      r_cand     <= '0;
      r_window   <= '0;
      r_filt_out <= '0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (filt_en) begin
            r_row  <= s_row;
            r_col  <= s_col;
            r_mode <= border_mode;
            r_i    <= '0;
            r_j    <= '0;
            r_n    <= '0;
          end
        end
        ADDR: begin
          if (w_skip) r_window[r_n] <= '0;
          else        r_mem_addr    <= w_addr;
        end
        WAIT: if (mem_drdy) r_window[r_n] <= mem_odata;
        NEXT: begin
          if (r_n == IW'(K - 1)) begin
            r_cand <= '0;
          end else begin
            r_n <= r_n + 1'b1;
            if (r_j == JW'(WINDOW_SIZE - 1)) begin
              r_j <= '0;
              r_i <= r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end
        end
        RANK: begin
          if (w_qual) r_filt_out <= r_window[r_cand];
          else        r_cand     <= r_cand + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
